// File: rtl/tx_data_fifo.sv
// Show-ahead byte FIFO between the AHB-side slave and the USB TX serializer.
// Flags come from a registered occupancy count. Error flags are sticky until flush or reset.
module tx_data_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_tx_data,
  input  logic [7:0]                 tx_data,
  input  logic                       get_tx_packet_data,
  input  logic                       flush,
  output logic [7:0]                 tx_packet_data,
  output logic [$clog2(DEPTH):0]     buffer_occupancy,
  output logic                       buffer_full,
  output logic                       buffer_empty,
  output logic                       overflow_err,
  output logic                       underflow_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          full, empty, wr_en, rd_en;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign wr_en = store_tx_data && !full && !flush;
  assign rd_en = get_tx_packet_data && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
      if (store_tx_data && full)      ovf_d = 1'b1;
      if (get_tx_packet_data && empty) udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is never cleared; the empty check below hides stale bytes.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= tx_data;
  end

  assign tx_packet_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign buffer_occupancy = occ_q;
  assign buffer_full      = full;
  assign buffer_empty     = empty;
  assign overflow_err     = ovf_q;
  assign underflow_err    = udf_q;

endmodule

// File: tb/tb_tx_data_fifo.sv
// Scoreboard bench for tx_data_fifo: a queue models the FIFO contents.
// Each test task drives stimulus and checks its own results inline.
module tb_tx_data_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       store_tx_data = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       get_tx_packet_data = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       buffer_full, buffer_empty, overflow_err, underflow_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] popped_exp, popped_act;

  tx_data_fifo #(.DEPTH(64)) dut (
    .clk(clk), .rst(rst), .store_tx_data(store_tx_data), .tx_data(tx_data),
    .get_tx_packet_data(get_tx_packet_data), .flush(flush),
    .tx_packet_data(tx_packet_data), .buffer_occupancy(buffer_occupancy),
    .buffer_full(buffer_full), .buffer_empty(buffer_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; updates the scoreboard and leaves outputs settled 1 ns after the edge.
  task automatic drive(input logic st, input logic [7:0] d, input logic pop, input logic fl);
    logic wr_ok, rd_ok;
    store_tx_data = st; tx_data = d; get_tx_packet_data = pop; flush = fl;
    #1;
    popped_act = tx_packet_data;
    popped_exp = 8'h00;
    if (fl) begin
      sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      wr_ok = st && (sb.size() < 64);
      rd_ok = pop && (sb.size() > 0);
      if (st && !wr_ok) m_ovf = 1'b1;
      if (pop && !rd_ok) m_udf = 1'b1;
      if (rd_ok) popped_exp = sb.pop_front();
      if (wr_ok) sb.push_back(d);
    end
    @(posedge clk); #1;
    store_tx_data = 1'b0; get_tx_packet_data = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", buffer_occupancy); end
    checks++; if (buffer_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", buffer_empty); end
    checks++; if (buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", buffer_full); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL reset_errs got=%b%b exp=00", overflow_err, underflow_err); end
    checks++; if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", tx_packet_data); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    drive(1'b1, 8'hA5, 1'b0, 1'b0);
    checks++; if (tx_packet_data !== 8'hA5) begin errors++; $display("FAIL basic_latency got=%h exp=a5", tx_packet_data); end
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL basic_occ2 got=%0d exp=2", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'hA5) begin errors++; $display("FAIL basic_head got=%h exp=a5", tx_packet_data); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (popped_act !== popped_exp) begin errors++; $display("FAIL basic_pop got=%h exp=%h", popped_act, popped_exp); end
    checks++; if (buffer_occupancy !== 7'd1) begin errors++; $display("FAIL basic_occ1 got=%0d exp=1", buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'h3C) begin errors++; $display("FAIL basic_head2 got=%h exp=3c", tx_packet_data); end
    $display("test_basic done");
  endtask

  task automatic test_full_overflow();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    checks++; if (buffer_full !== 1'b1 || buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_flag got=%b/%0d exp=1/64", buffer_full, buffer_occupancy); end
    drive(1'b1, 8'hFF, 1'b0, 1'b0);
    checks++; if (overflow_err !== 1'b1 || buffer_occupancy !== 7'd64) begin errors++; $display("FAIL overflow got=%b/%0d exp=1/64", overflow_err, buffer_occupancy); end
    for (int i = 0; i < 64; i++) begin
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      checks++; if (popped_act !== 8'(i) || popped_exp !== 8'(i)) begin errors++; $display("FAIL drain_%0d got=%h exp=%h", i, popped_act, 8'(i)); end
    end
    checks++; if (buffer_empty !== 1'b1 || tx_packet_data !== 8'h00) begin errors++; $display("FAIL drain_empty got=%b/%h exp=1/00", buffer_empty, tx_packet_data); end
    checks++; if (overflow_err !== m_ovf) begin errors++; $display("FAIL ovf_sticky got=%b exp=%b", overflow_err, m_ovf); end
    $display("test_full_overflow done");
  endtask

  task automatic test_underflow();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (underflow_err !== 1'b1) begin errors++; $display("FAIL underflow got=%b exp=1", underflow_err); end
    checks++; if (buffer_occupancy !== 7'd0 || tx_packet_data !== 8'h00) begin errors++; $display("FAIL underflow_state got=%0d/%h exp=0/00", buffer_occupancy, tx_packet_data); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (underflow_err !== 1'b0) begin errors++; $display("FAIL underflow_clear got=%b exp=0", underflow_err); end
    $display("test_underflow done");
  endtask

  task automatic test_back_to_back();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom_range(255)), 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'($urandom_range(255)), 1'b1, 1'b0);
      checks++; if (popped_act !== popped_exp) begin errors++; $display("FAIL b2b_pop_%0d got=%h exp=%h", i, popped_act, popped_exp); end
    end
    checks++; if (buffer_occupancy !== 7'd10) begin errors++; $display("FAIL b2b_occ got=%0d exp=10", buffer_occupancy); end
    checks++; if (tx_packet_data !== sb[0]) begin errors++; $display("FAIL b2b_head got=%h exp=%h", tx_packet_data, sb[0]); end
    $display("test_back_to_back done");
  endtask

  task automatic test_edge_simul();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) drive(1'b1, 8'(i + 100), 1'b0, 1'b0);
    drive(1'b1, 8'hEE, 1'b1, 1'b0);
    checks++; if (overflow_err !== 1'b1 || buffer_occupancy !== 7'd63) begin errors++; $display("FAIL full_simul got=%b/%0d exp=1/63", overflow_err, buffer_occupancy); end
    checks++; if (popped_act !== 8'd100) begin errors++; $display("FAIL full_simul_pop got=%h exp=64", popped_act); end
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    checks++; if (underflow_err !== 1'b1 || buffer_occupancy !== 7'd1) begin errors++; $display("FAIL empty_simul got=%b/%0d exp=1/1", underflow_err, buffer_occupancy); end
    checks++; if (tx_packet_data !== 8'h5A) begin errors++; $display("FAIL empty_simul_head got=%h exp=5a", tx_packet_data); end
    $display("test_edge_simul done");
  endtask

  task automatic test_flush_rst();
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
    drive(1'b1, 8'h77, 1'b0, 1'b1);
    checks++; if (buffer_occupancy !== 7'd0 || buffer_empty !== 1'b1) begin errors++; $display("FAIL flush_state got=%0d/%b exp=0/1", buffer_occupancy, buffer_empty); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00) begin errors++; $display("FAIL flush_errs got=%b%b exp=00", overflow_err, underflow_err); end
    checks++; if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL flush_data got=%h exp=00", tx_packet_data); end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(i + 1), 1'b0, 1'b0);
    checks++; if (buffer_occupancy !== 7'd5 || underflow_err !== 1'b1) begin errors++; $display("FAIL prerst got=%0d/%b exp=5/1", buffer_occupancy, underflow_err); end
    rst = 1'b1; store_tx_data = 1'b1; tx_data = 8'h99; get_tx_packet_data = 1'b1; flush = 1'b1;
    sb.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; store_tx_data = 1'b0; get_tx_packet_data = 1'b0; flush = 1'b0;
    checks++; if (buffer_occupancy !== 7'd0 || buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin errors++; $display("FAIL rst_flags got=%0d/%b/%b exp=0/1/0", buffer_occupancy, buffer_empty, buffer_full); end
    checks++; if ({overflow_err, underflow_err} !== 2'b00 || tx_packet_data !== 8'h00) begin errors++; $display("FAIL rst_outs got=%b%b/%h exp=00/00", overflow_err, underflow_err, tx_packet_data); end
    drive(1'b1, 8'h42, 1'b0, 1'b0);
    checks++; if (tx_packet_data !== 8'h42 || buffer_occupancy !== 7'd1) begin errors++; $display("FAIL post_rst got=%h/%0d exp=42/1", tx_packet_data, buffer_occupancy); end
    $display("test_flush_rst done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_underflow();
    test_back_to_back();
    test_edge_simul();
    test_flush_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
